// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin burst scheduler that drains N_REQ upstream
// FIFOs into one shared downstream FIFO. Each grant pops up to MAX_BURST
// words, and each popped word is pushed downstream two cycles after its pop.
// Optional feature macro: FIFO_ARB_PRIO_EN adds prio_in. When prio_in is
// present, requesters with a prio bit set are scanned first. A burst that is
// already running is never preempted.
module fifo_rr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 6,
  parameter int GRANT_W   = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    RESET_L,
  input  logic [N_REQ-1:0]        fifo_empty_in,
  input  logic [N_REQ-1:0]        valid_in,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  input  logic                    pause_in,
`ifdef FIFO_ARB_PRIO_EN
  input  logic [N_REQ-1:0]        prio_in,
`endif
  output logic [N_REQ-1:0]        fifo_rd_out,
  output logic [DATA_W-1:0]       data_out,
  output logic                    push_out,
  output logic [GRANT_W-1:0]      grant,
  output logic                    active,
  output logic                    err_arb
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t               state_r, state_nx_s;
  logic [GRANT_W-1:0]   grant_r, last_grant_r, base_s, sel_idx_s, grant_q_r;
  logic [2:0]           burst_cnt_r;
  logic [N_REQ-1:0]     req_s;
  logic [GRANT_W:0]     pick_rr_s, pick_s;
`ifdef FIFO_ARB_PRIO_EN
  logic [GRANT_W:0]     pick_hi_s;
`endif
  logic                 sel_found_s, go_s, pop_s, pop_q_r, last_pop_s;

  // Returns {found, index}: the first set mask bit after base, wrapping around.
  function automatic logic [GRANT_W:0] rr_pick(input logic [N_REQ-1:0] mask,
                                               input logic [GRANT_W-1:0] base);
    logic [GRANT_W:0]   res;
    logic [GRANT_W-1:0] idx;
    res = '0;
    // Scan from the far end so that the nearest hit is the last one written.
    for (int k = N_REQ; k >= 1; k--) begin
      idx = GRANT_W'((int'(base) + k) % N_REQ);
      if (mask[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // Request decode and next-grant selection. In SWITCH the rotation already
  // starts after the grant that just finished.
  always_comb begin
    req_s     = ~fifo_empty_in;
    base_s    = (state_r == SWITCH) ? grant_r : last_grant_r;
    pick_rr_s = rr_pick(req_s, base_s);
`ifdef FIFO_ARB_PRIO_EN
    pick_hi_s = rr_pick(req_s & prio_in, base_s);
    if (pick_hi_s[GRANT_W]) begin
      pick_s = pick_hi_s;
    end else begin
      pick_s = pick_rr_s;
    end
`else
    pick_s = pick_rr_s;
`endif
    sel_found_s = pick_s[GRANT_W];
    sel_idx_s   = pick_s[GRANT_W-1:0];
    go_s        = ~pause_in & sel_found_s;
  end

  // Next state and pop strobe. pause_in gates the pop in the same cycle.
  always_comb begin
    state_nx_s  = state_r;
    pop_s       = 1'b0;
    last_pop_s  = 1'b0;
    fifo_rd_out = '0;
    active      = 1'b0;
    case (state_r)
      IDLE: begin
        if (go_s) begin
          state_nx_s = BURST;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BURST: begin
        active     = 1'b1;
        pop_s      = req_s[grant_r] & ~pause_in;
        last_pop_s = pop_s & (burst_cnt_r == 3'(MAX_BURST - 1));
        fifo_rd_out[grant_r] = pop_s;
        if (last_pop_s || !req_s[grant_r] || pause_in) begin
          state_nx_s = SWITCH;
        end else begin
          state_nx_s = BURST;
        end
      end
      SWITCH: begin
        if (go_s) begin
          state_nx_s = BURST;
        end else begin
          state_nx_s = IDLE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register, grant rotation and burst length counter.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      state_r      <= IDLE;
      grant_r      <= '0;
      last_grant_r <= GRANT_W'(N_REQ - 1);
      burst_cnt_r  <= 3'd0;
    end else begin
      state_r <= state_nx_s;
      case (state_r)
        IDLE: begin
          if (go_s) begin
            grant_r     <= sel_idx_s;
            burst_cnt_r <= 3'd0;
          end
        end
        BURST: begin
          if (pop_s) begin
            burst_cnt_r <= last_pop_s ? 3'd0 : burst_cnt_r + 3'd1;
          end
        end
        SWITCH: begin
          last_grant_r <= grant_r;
          if (go_s) begin
            grant_r     <= sel_idx_s;
            burst_cnt_r <= 3'd0;
          end
        end
        default: begin
          burst_cnt_r <= 3'd0;
        end
      endcase
    end
  end

  // One-deep pop history so the read data can be matched one cycle later.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      pop_q_r   <= 1'b0;
      grant_q_r <= '0;
    end else begin
      pop_q_r   <= pop_s;
      grant_q_r <= grant_r;
    end
  end

  // Capture the popped word and push it downstream. A missing valid is
  // recorded as a sticky error, and nothing is pushed for it.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      push_out <= 1'b0;
      data_out <= '0;
      err_arb  <= 1'b0;
    end else begin
      push_out <= pop_q_r & valid_in[grant_q_r];
      data_out <= (pop_q_r & valid_in[grant_q_r]) ?
                  data_in[int'(grant_q_r)*DATA_W +: DATA_W] : '0;
      err_arb  <= err_arb | (pop_q_r & ~valid_in[grant_q_r]);
    end
  end

  assign grant = grant_r;

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
Round-robin burst scheduler that shares one downstream FIFO between N_REQ upstream 6-bit FIFOs. It watches the upstream empty flags and the downstream pause flag, and issues pop strobes to one upstream FIFO at a time. It captures the popped word and pushes it into the downstream FIFO. It sits between the per-class input FIFOs and the shared output FIFO of the datapath.

Parameters:
N_REQ, 4, number of upstream FIFOs/requesters
DATA_W, 6, word width
GRANT_W, 2, width of grant index (clog2 N_REQ)
MAX_BURST, 4, maximum consecutive pops per grant (1..7)

Ports:
clk  in  1  clock, all state on rising edge
RESET_L  in  1  asynchronous active-low reset
fifo_empty_in  in  N_REQ  fifo_empty of each upstream FIFO
valid_in  in  N_REQ  valid_out of each upstream FIFO (read data valid)
data_in  in  N_REQ*DATA_W  packed upstream data_out, requester i at [i*DATA_W +: DATA_W]
pause_in  in  1  pause of downstream FIFO
fifo_rd_out  out  N_REQ  one-hot pop strobes to upstream FIFOs
data_out  out  DATA_W  word to downstream FIFO data_in
push_out  out  1  downstream fifo_wr
grant  out  GRANT_W  index of current/last granted requester
active  out  1  high while in BURST
err_arb  out  1  sticky protocol error

Behaviour:
- Reset (async, RESET_L=0): state=IDLE, last_grant=N_REQ-1, burst_cnt=0, fifo_rd_out=0, push_out=0, data_out=0, grant=0, active=0, err_arb=0. In-flight words are dropped. Reset mid-burst clears outputs immediately, without waiting for clk.
- req[i] = ~fifo_empty_in[i]. Selection: the first set req scanning i = last_grant+1 .. last_grant+N_REQ, mod N_REQ.
- States (2-bit): IDLE, BURST, SWITCH.
- IDLE: no pops. If ~pause_in and |req: grant<=selected, burst_cnt<=0, go to BURST. Else stay.
- BURST: active=1. pop = req[grant] & ~pause_in, and fifo_rd_out[grant]=pop (combinational, so pause_in blocks a pop in the same cycle). On pop, burst_cnt++. Go to SWITCH when (pop & burst_cnt==MAX_BURST-1), or ~req[grant], or pause_in.
- SWITCH: no pops; last_grant<=grant. If ~pause_in and |req, select (using the updated rotation) and go to BURST, burst_cnt<=0. Else go to IDLE.
- Datapath latency: pop at cycle t. Upstream data/valid are present at t+1 and registered. data_out/push_out appear at t+2 for exactly one cycle per pop. Pop history is held in a 1-deep pipe (pop_q, grant_q).
- Words are pushed in pop order; no reordering or loss except on reset.
- If pop_q=1 and valid_in[grant_q]=0 at t+1: err_arb<=1 and no push. err_arb stays set until reset.
- Up to 2 words remain in flight after pause_in rises. The downstream almost-full threshold must leave >=2 free slots.
- burst_cnt width is 3 bits; it never exceeds MAX_BURST-1.
- grant holds its value in IDLE/SWITCH. After reset, the first grant is requester 0 when req[0]=1.

Optional Feature:
FIFO_ARB_PRIO_EN: adds input prio_in[N_REQ-1:0], driven by the upstream FIFOs' pause (almost-full) flags. Selection first scans only req & prio_in in round-robin order, and falls back to plain req only if none is set. A BURST in progress is not preempted. Without the macro the port is absent and selection is pure round-robin.

Test Plan:
- FIFO1 holds 3 words {0x11,0x12,0x13}, others empty, pause 0 -> one IDLE cycle, then fifo_rd_out=0010 for 3 cycles; grant=1; push_out pulses at pop+2 with data 0x11,0x12,0x13; then SWITCH to IDLE.
- All 4 FIFOs hold 6 words, MAX_BURST=4 -> bursts of 4 pops in grant order 0,1,2,3,0,1,2,3, with one idle SWITCH cycle between bursts; 24 pushes, per-requester order preserved.
- FIFO2 streaming; pause_in rises after the 2nd pop -> fifo_rd_out=0 in that same cycle; 2 in-flight pushes still emerge; then SWITCH to IDLE. On pause_in fall, the next grant goes to requester 3 if it is non-empty.
- Pop issued while valid_in forced 0 -> err_arb=1 at t+2, no push; err_arb remains 1 until RESET_L=0.
- RESET_L pulled low mid-burst between clk edges -> all outputs 0 immediately. After release with all FIFOs non-empty, first grant=0.
- With FIFO_ARB_PRIO_EN, req=1111, prio_in=0100, last_grant=0 -> next grant=2, not 1.
